// File: rtl/sync_fifo_param_if.sv
// Request/status bundle between the host register side and the FIFO.
interface sync_fifo_param_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 7
);
  logic [DATA_W-1:0] data_i;
  logic              n_we_i;
  logic              n_re_i;
  logic              clr_err_i;
  logic [DATA_W-1:0] data_o;
  logic              p_empty_o;
  logic              p_full_o;
  logic              p_afull_o;
  logic              p_aempty_o;
  logic [ADDR_W:0]   count_o;
  logic              p_ovf_o;
  logic              p_udf_o;

  // Host side: issues requests, observes data and status.
  modport master (
    output data_i, n_we_i, n_re_i, clr_err_i,
    input  data_o, p_empty_o, p_full_o, p_afull_o, p_aempty_o, count_o, p_ovf_o, p_udf_o
  );

  // FIFO side.
  modport slave (
    input  data_i, n_we_i, n_re_i, clr_err_i,
    output data_o, p_empty_o, p_full_o, p_afull_o, p_aempty_o, count_o, p_ovf_o, p_udf_o
  );
endinterface

// File: rtl/sync_fifo_param.sv
// Parametrised synchronous FIFO for the UART TX/RX buffering paths.
// All 2**ADDR_W entries usable; registered read data with 1-cycle latency;
// status flags registered from the next occupancy so they track count_o exactly.
module sync_fifo_param #(
  parameter int DATA_W    = 8,
  parameter int ADDR_W    = 7,
  parameter int AFULL_TH  = 120,
  parameter int AEMPTY_TH = 8
) (
  input  logic             clk,
  input  logic             rst,
  sync_fifo_param_if.slave bus
);
  localparam int                CNT_W    = ADDR_W + 1;
  localparam int                DEPTH    = 1 << ADDR_W;
  localparam logic [CNT_W-1:0]  DEPTH_C  = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0]  AFULL_C  = CNT_W'(AFULL_TH);
  localparam logic [CNT_W-1:0]  AEMPTY_C = CNT_W'(AEMPTY_TH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [CNT_W-1:0]  wr_ptr, rd_ptr;
  logic [CNT_W-1:0]  count_q, count_nxt;
  logic [DATA_W-1:0] rd_data_q;
  logic              empty_q, full_q, afull_q, aempty_q;
  logic              ovf_q, udf_q;
  logic              wr_req, rd_req, wr_acc, rd_acc;

  assign wr_req = !bus.n_we_i;
  assign rd_req = !bus.n_re_i;
  // A full FIFO still takes a write when a read frees a slot in the same cycle.
  assign rd_acc = rd_req && !empty_q;
  assign wr_acc = wr_req && (!full_q || rd_acc);

  // Next occupancy: simultaneous read and write cancel out.
  always_comb begin
    count_nxt = count_q;
    if (wr_acc && !rd_acc)
      count_nxt = count_q + 1'b1;
    else if (rd_acc && !wr_acc)
      count_nxt = count_q - 1'b1;
  end

  // Storage array; contents are intentionally not reset.
  always_ff @(posedge clk) begin
    if (wr_acc)
      mem[wr_ptr[ADDR_W-1:0]] <= bus.data_i;
  end

  // Pointers, read data register, occupancy and status flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count_q   <= '0;
      rd_data_q <= '0;
      empty_q   <= 1'b1;
      full_q    <= 1'b0;
      afull_q   <= 1'b0;
      aempty_q  <= 1'b1;
    end else begin
      if (wr_acc)
        wr_ptr <= wr_ptr + 1'b1;
      if (rd_acc) begin
        rd_ptr    <= rd_ptr + 1'b1;
        rd_data_q <= mem[rd_ptr[ADDR_W-1:0]];
      end
      count_q  <= count_nxt;
      empty_q  <= (count_nxt == '0);
      full_q   <= (count_nxt == DEPTH_C);
      afull_q  <= (count_nxt >= AFULL_C);
      aempty_q <= (count_nxt <= AEMPTY_C);
    end
  end

  // Sticky error flags; a new error in the clearing cycle wins over the clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf_q <= 1'b0;
      udf_q <= 1'b0;
    end else begin
      if (wr_req && !wr_acc)
        ovf_q <= 1'b1;
      else if (bus.clr_err_i)
        ovf_q <= 1'b0;
      if (rd_req && !rd_acc)
        udf_q <= 1'b1;
      else if (bus.clr_err_i)
        udf_q <= 1'b0;
    end
  end

  assign bus.data_o     = rd_data_q;
  assign bus.count_o    = count_q;
  assign bus.p_empty_o  = empty_q;
  assign bus.p_full_o   = full_q;
  assign bus.p_afull_o  = afull_q;
  assign bus.p_aempty_o = aempty_q;
  assign bus.p_ovf_o    = ovf_q;
  assign bus.p_udf_o    = udf_q;
endmodule

// File: tb/tb_sync_fifo_param.sv
// Directed bench for sync_fifo_param at DEPTH=4, AFULL_TH=3, AEMPTY_TH=1.
module tb_sync_fifo_param;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   npass = 0;
  int   ntotal = 0;

  sync_fifo_param_if #(.DATA_W(8), .ADDR_W(2)) bus ();

  sync_fifo_param #(.DATA_W(8), .ADDR_W(2), .AFULL_TH(3), .AEMPTY_TH(1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Flag vector order: {empty, full, afull, aempty, ovf, udf}
  function automatic logic [5:0] flags();
    return {bus.p_empty_o, bus.p_full_o, bus.p_afull_o, bus.p_aempty_o, bus.p_ovf_o, bus.p_udf_o};
  endfunction

  // One clock with the given requests, then return to idle; sampled 1 time unit after the edge.
  task automatic cyc(input logic we, input logic [7:0] d, input logic re, input logic clr);
    bus.n_we_i    = ~we;
    bus.data_i    = d;
    bus.n_re_i    = ~re;
    bus.clr_err_i = clr;
    @(posedge clk);
    #1;
    bus.n_we_i    = 1'b1;
    bus.n_re_i    = 1'b1;
    bus.clr_err_i = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    ntotal++;
    if (flags() !== 6'b100100 || bus.count_o !== 3'd0 || bus.data_o !== 8'h00)
      $display("FAIL reset: flags=%b count=%0d data=%h, want flags=100100 count=0 data=00",
               flags(), bus.count_o, bus.data_o);
    else npass++;
  endtask

  task automatic test_basic();
    cyc(1, 8'hA1, 0, 0);
    ntotal++;
    if (bus.count_o !== 3'd1 || flags() !== 6'b000100)
      $display("FAIL basic_w1: count=%0d flags=%b, want 1 000100", bus.count_o, flags());
    else npass++;
    cyc(1, 8'hA2, 0, 0);
    ntotal++;
    if (bus.count_o !== 3'd2 || flags() !== 6'b000000)
      $display("FAIL basic_w2: count=%0d flags=%b, want 2 000000", bus.count_o, flags());
    else npass++;
    cyc(0, 8'h00, 1, 0);
    ntotal++;
    if (bus.data_o !== 8'hA1 || bus.count_o !== 3'd1)
      $display("FAIL basic_r1: data=%h count=%0d, want A1 1", bus.data_o, bus.count_o);
    else npass++;
    cyc(0, 8'h00, 1, 0);
    ntotal++;
    if (bus.data_o !== 8'hA2 || flags() !== 6'b100100 || bus.count_o !== 3'd0)
      $display("FAIL basic_r2: data=%h flags=%b count=%0d, want A2 100100 0",
               bus.data_o, flags(), bus.count_o);
    else npass++;
  endtask

  task automatic test_full_ovf();
    logic [7:0] exp_d;
    cyc(1, 8'h10, 0, 0);
    cyc(1, 8'h11, 0, 0);
    cyc(1, 8'h12, 0, 0);
    ntotal++;
    if (flags() !== 6'b001000 || bus.count_o !== 3'd3)
      $display("FAIL afull_3: flags=%b count=%0d, want 001000 3", flags(), bus.count_o);
    else npass++;
    cyc(1, 8'h13, 0, 0);
    ntotal++;
    if (flags() !== 6'b011000 || bus.count_o !== 3'd4)
      $display("FAIL full_4: flags=%b count=%0d, want 011000 4", flags(), bus.count_o);
    else npass++;
    cyc(1, 8'h14, 0, 0);
    ntotal++;
    if (flags() !== 6'b011010 || bus.count_o !== 3'd4)
      $display("FAIL ovf: flags=%b count=%0d, want 011010 4", flags(), bus.count_o);
    else npass++;
    for (int i = 0; i < 4; i++) begin
      exp_d = 8'h10 + 8'(i);
      cyc(0, 8'h00, 1, 0);
      ntotal++;
      if (bus.data_o !== exp_d)
        $display("FAIL ovf_read%0d: data=%h, want %h", i, bus.data_o, exp_d);
      else npass++;
    end
    ntotal++;
    if (bus.p_empty_o !== 1'b1 || bus.count_o !== 3'd0)
      $display("FAIL ovf_drain: empty=%b count=%0d, want 1 0", bus.p_empty_o, bus.count_o);
    else npass++;
  endtask

  task automatic test_full_rw();
    logic [7:0] exp_d [4] = '{8'h11, 8'h12, 8'h13, 8'h55};
    cyc(0, 8'h00, 0, 1);
    for (int i = 0; i < 4; i++) cyc(1, 8'h10 + 8'(i), 0, 0);
    cyc(1, 8'h55, 1, 0);
    ntotal++;
    if (bus.data_o !== 8'h10 || bus.count_o !== 3'd4 || flags() !== 6'b011000)
      $display("FAIL full_rw: data=%h count=%0d flags=%b, want 10 4 011000",
               bus.data_o, bus.count_o, flags());
    else npass++;
    for (int i = 0; i < 4; i++) begin
      cyc(0, 8'h00, 1, 0);
      ntotal++;
      if (bus.data_o !== exp_d[i])
        $display("FAIL full_rw_read%0d: data=%h, want %h", i, bus.data_o, exp_d[i]);
      else npass++;
    end
  endtask

  task automatic test_underflow();
    cyc(0, 8'h00, 1, 0);
    ntotal++;
    if (bus.p_udf_o !== 1'b1 || bus.data_o !== 8'h55 || bus.count_o !== 3'd0)
      $display("FAIL udf: udf=%b data=%h count=%0d, want 1 55 0", bus.p_udf_o, bus.data_o, bus.count_o);
    else npass++;
    cyc(0, 8'h00, 0, 1);
    ntotal++;
    if (bus.p_udf_o !== 1'b0)
      $display("FAIL udf_clr: udf=%b, want 0", bus.p_udf_o);
    else npass++;
    cyc(0, 8'h00, 1, 1);
    ntotal++;
    if (bus.p_udf_o !== 1'b1 || bus.data_o !== 8'h55)
      $display("FAIL udf_set_wins: udf=%b data=%h, want 1 55", bus.p_udf_o, bus.data_o);
    else npass++;
    cyc(0, 8'h00, 0, 1);
  endtask

  task automatic test_wrap();
    for (int i = 0; i < 10; i++) begin
      cyc(1, 8'(i), 0, 0);
      ntotal++;
      if (bus.count_o !== 3'd1 || flags() !== 6'b000100)
        $display("FAIL wrap_w%0d: count=%0d flags=%b, want 1 000100", i, bus.count_o, flags());
      else npass++;
      cyc(0, 8'h00, 1, 0);
      ntotal++;
      if (bus.data_o !== 8'(i) || bus.count_o !== 3'd0 || flags() !== 6'b100100)
        $display("FAIL wrap_r%0d: data=%h count=%0d flags=%b, want %h 0 100100",
                 i, bus.data_o, bus.count_o, flags(), 8'(i));
      else npass++;
    end
  endtask

  task automatic test_async_reset();
    cyc(1, 8'hE0, 0, 0);
    cyc(1, 8'hE1, 0, 0);
    cyc(1, 8'hE2, 0, 0);
    cyc(0, 8'h00, 1, 0);
    cyc(1, 8'hE3, 0, 0);
    ntotal++;
    if (bus.count_o !== 3'd3 || bus.data_o !== 8'hE0)
      $display("FAIL pre_rst: count=%0d data=%h, want 3 E0", bus.count_o, bus.data_o);
    else npass++;
    #2 rst = 1'b1;
    #1;
    ntotal++;
    if (flags() !== 6'b100100 || bus.count_o !== 3'd0 || bus.data_o !== 8'h00)
      $display("FAIL async_rst: flags=%b count=%0d data=%h, want 100100 0 00",
               flags(), bus.count_o, bus.data_o);
    else npass++;
    @(posedge clk);
    #1 rst = 1'b0;
    cyc(1, 8'h77, 0, 0);
    cyc(0, 8'h00, 1, 0);
    ntotal++;
    if (bus.data_o !== 8'h77 || bus.count_o !== 3'd0 || flags() !== 6'b100100)
      $display("FAIL post_rst: data=%h count=%0d flags=%b, want 77 0 100100",
               bus.data_o, bus.count_o, flags());
    else npass++;
  endtask

  initial begin
    bus.data_i    = 8'h00;
    bus.n_we_i    = 1'b1;
    bus.n_re_i    = 1'b1;
    bus.clr_err_i = 1'b0;
    test_reset();
    test_basic();
    test_full_ovf();
    test_full_rw();
    test_underflow();
    test_wrap();
    test_async_reset();
    $display("%0d/%0d checks passed", npass, ntotal);
    $finish;
  end
endmodule
